// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: byte-addressed program store with a word load
// port and a one-cycle fetch port supporting stall, flush and fault reporting.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   ld_en, ld_addr, ld_data          program-load write port
//   req, address, stall, flush       fetch request and pipeline control
//   instruction, inst_valid, fault   fetch result
//   fetch_count                      running count of valid fetches
module inst_fetch_mem #(
  parameter int          DEPTH      = 256,
  parameter int          ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [31:0] NOP_WORD   = 32'hE000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  localparam int IW = $clog2(DEPTH);
  // Highest word base whose last byte still fits in storage.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 4);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ld_base;
  logic              ld_ok;
  logic              fetch_bad;
  logic              bypass;
  logic [IW-1:0]     f_idx;
  logic [IW-1:0]     w_idx;
  logic [7:0]        rd_b [4];
  logic [31:0]       mem_word;
  logic [31:0]       fetch_word;

  assign ld_base   = ld_addr & ~ADDR_W'(3);
  assign ld_ok     = ld_en && (ld_base <= LAST);
  assign fetch_bad = (address[1:0] != 2'b00) || (address > LAST);
  // Same-edge load to the fetched word wins over the stored copy.
  assign bypass    = ld_ok && (ld_base == address);
  assign f_idx     = address[IW-1:0];
  assign w_idx     = ld_base[IW-1:0];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_b[i] = mem[f_idx + IW'(i)];
    end
    if (BIG_ENDIAN) begin
      mem_word = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
    end else begin
      mem_word = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
    end
    fetch_word = bypass ? ld_data : mem_word;
  end

  // Storage keeps its contents through reset; reset only blocks writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (ld_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (BIG_ENDIAN) begin
          mem[w_idx + IW'(i)] <= ld_data[8*(3-i) +: 8];
        end else begin
          mem[w_idx + IW'(i)] <= ld_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_WORD;
      inst_valid  <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else if (flush) begin
      instruction <= NOP_WORD;
      inst_valid  <= 1'b0;
      fault       <= 1'b0;
    end else if (stall) begin
      instruction <= instruction;
    end else if (req) begin
      instruction <= fetch_bad ? NOP_WORD : fetch_word;
      inst_valid  <= 1'b1;
      fault       <= fetch_bad;
      fetch_count <= fetch_count + 32'd1;
    end else begin
      inst_valid  <= 1'b0;
      fault       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Testbench for inst_fetch_mem: directed vector table, hand sequences for
// reset and byte order, and randomized traffic against a behavioural model.
module tb_inst_fetch_mem;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'hE000_0000;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        req;
  logic [31:0] address;
  logic        stall;
  logic        flush;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] le_instruction;
  logic        le_valid;
  logic        le_fault;
  logic [31:0] le_count;

  inst_fetch_mem #(
    .DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b1), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .req(req), .address(address), .stall(stall),
    .flush(flush), .instruction(instruction), .inst_valid(inst_valid),
    .fault(fault), .fetch_count(fetch_count)
  );

  inst_fetch_mem #(
    .DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b0), .NOP_WORD(NOP)
  ) dut_le (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .req(req), .address(address), .stall(stall),
    .flush(flush), .instruction(le_instruction), .inst_valid(le_valid),
    .fault(le_fault), .fetch_count(le_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;

  logic [7:0]  m_mem [DEPTH];
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_cnt;

  typedef struct {
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        req;
    logic [31:0] address;
    logic        stall;
    logic        flush;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t v(
    input logic le, input logic [31:0] la, input logic [31:0] ld,
    input logic rq, input logic [31:0] ad, input logic st, input logic fl,
    input logic [31:0] ei, input logic ev, input logic ef,
    input logic [31:0] ec);
    vec_t r;
    r.ld_en = le; r.ld_addr = la; r.ld_data = ld;
    r.req = rq; r.address = ad; r.stall = st; r.flush = fl;
    r.e_instr = ei; r.e_valid = ev; r.e_fault = ef; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic drive(input logic le, input logic [31:0] la,
                       input logic [31:0] ld, input logic rq,
                       input logic [31:0] ad, input logic st,
                       input logic fl);
    ld_en = le; ld_addr = la; ld_data = ld;
    req = rq; address = ad; stall = st; flush = fl;
  endtask

  // Behavioural model: memory is a big-endian byte array, the load is
  // applied before the fetch so a same-edge load is seen by the fetch.
  task automatic model_step();
    longint a;
    logic   bad;
    if (rst) begin
      m_instr = NOP; m_valid = 0; m_fault = 0; m_cnt = 0;
      return;
    end
    if (ld_en) begin
      a = longint'(ld_addr) - longint'(ld_addr % 4);
      if (a + 3 < DEPTH)
        for (int i = 0; i < 4; i++)
          m_mem[a + i] = 8'((ld_data >> (8 * (3 - i))) & 32'hFF);
    end
    if (flush) begin
      m_instr = NOP; m_valid = 0; m_fault = 0;
    end else if (stall) begin
    end else if (req) begin
      a = longint'(address);
      bad = (address % 4 != 0) || (a + 3 >= DEPTH);
      m_instr = bad ? NOP :
        {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
      m_valid = 1;
      m_fault = bad;
      m_cnt = m_cnt + 1;
    end else begin
      m_valid = 0; m_fault = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_chk(input string tag);
    chk({tag, " instr"}, instruction, m_instr);
    chk({tag, " valid"}, 32'(inst_valid), 32'(m_valid));
    chk({tag, " fault"}, 32'(fault), 32'(m_fault));
    chk({tag, " count"}, fetch_count, m_cnt);
    chk({tag, " le_instr"}, le_instruction, m_instr);
    chk({tag, " le_count"}, le_count, m_cnt);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return $urandom;
    if (r < 3) return 32'($urandom_range(DEPTH + 8, DEPTH - 8));
    return ($urandom % (DEPTH / 4)) * 4;
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    m_instr = NOP; m_valid = 0; m_fault = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("reset instr", instruction, NOP);
    chk("reset valid", 32'(inst_valid), 0);
    chk("reset fault", 32'(fault), 0);
    chk("reset count", fetch_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Preload every word so the model and both DUTs agree on contents.
    for (int w = 0; w < DEPTH / 4; w++) begin
      drive(1, 32'(w * 4), 32'hC0DE_0000 | 32'(w * 4), 0, 0, 0, 0);
      tick();
    end
    model_chk("preload");

    tv.push_back(v(1, 0, 32'hE3A00014, 0, 0, 0, 0, NOP, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'hE3A00014, 1, 0, 1));
    tv.push_back(v(0, 0, 0, 1, 2, 0, 0, NOP, 1, 1, 2));
    tv.push_back(v(0, 0, 0, 1, DEPTH - 2, 0, 0, NOP, 1, 1, 3));
    tv.push_back(v(0, 0, 0, 1, 12, 0, 0, 32'hC0DE000C, 1, 0, 4));
    tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 32'hC0DE000C, 1, 0, 4));
    tv.push_back(v(0, 0, 0, 1, 4, 1, 0, 32'hC0DE000C, 1, 0, 4));
    tv.push_back(v(0, 0, 0, 1, 252, 1, 0, 32'hC0DE000C, 1, 0, 4));
    tv.push_back(v(0, 0, 0, 1, 0, 1, 1, NOP, 0, 0, 4));
    tv.push_back(v(1, 8, 32'hDEADBEEF, 1, 8, 0, 0, 32'hDEADBEEF, 1, 0, 5));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 5));
    tv.push_back(v(0, 0, 0, 1, 252, 0, 0, 32'hC0DE00FC, 1, 0, 6));
    tv.push_back(v(0, 0, 0, 1, 253, 0, 0, NOP, 1, 1, 7));
    tv.push_back(v(1, 256, 32'h12345678, 1, 252, 0, 0,
                   32'hC0DE00FC, 1, 0, 8));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'hE3A00014, 1, 0, 9));
    tv.push_back(v(1, 7, 32'h11223344, 1, 4, 0, 0, 32'h11223344, 1, 0, 10));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 1, NOP, 0, 0, 10));

    foreach (tv[i]) begin
      drive(tv[i].ld_en, tv[i].ld_addr, tv[i].ld_data, tv[i].req,
            tv[i].address, tv[i].stall, tv[i].flush);
      tick();
      chk($sformatf("row%0d instr", i), instruction, tv[i].e_instr);
      chk($sformatf("row%0d valid", i), 32'(inst_valid), 32'(tv[i].e_valid));
      chk($sformatf("row%0d fault", i), 32'(fault), 32'(tv[i].e_fault));
      chk($sformatf("row%0d count", i), fetch_count, tv[i].e_cnt);
      chk($sformatf("row%0d le_instr", i), le_instruction, tv[i].e_instr);
    end

    // Byte placement in storage for each byte order.
    chk("be byte0", 32'(dut.mem[0]), 32'h0000_00E3);
    chk("be byte4", 32'(dut.mem[4]), 32'h0000_0011);
    chk("le byte4", 32'(dut_le.mem[4]), 32'h0000_0044);
    chk("le byte7", 32'(dut_le.mem[7]), 32'h0000_0011);

    // Reset asserted between edges takes effect at once.
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("pre-rst instr", instruction, 32'hE3A00014);
    chk("pre-rst count", fetch_count, 11);
    #2 rst = 1'b1;
    #1;
    chk("async rst instr", instruction, NOP);
    chk("async rst valid", 32'(inst_valid), 0);
    chk("async rst count", fetch_count, 0);
    chk("async rst le cnt", le_count, 0);
    drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    tick();
    chk("in-rst valid", 32'(inst_valid), 0);
    chk("in-rst count", fetch_count, 0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("post-rst instr", instruction, 32'hE3A00014);
    chk("post-rst valid", 32'(inst_valid), 1);
    chk("post-rst count", fetch_count, 1);
    model_chk("post-rst");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] la;
      la = pick_addr();
      drive(($urandom % 10) < 3, la, $urandom, ($urandom % 10) < 7,
            (($urandom % 4) == 0) ? la : pick_addr(),
            ($urandom % 100) < 20, ($urandom % 100) < 8);
      tick();
      model_chk($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
